// File: rtl/btn_scan_ctrl.sv
// btn_scan_ctrl: one prescaler and scan pointer time-share button debouncing; edges queue as
// round-robin events on a valid/ready port. Define BTN_SCAN_OVF_EN for sticky overwrite flags.
module btn_scan_ctrl #(
    parameter int  NBTN     = 4,
    parameter int  PRESCALE = 50000,
    parameter int  CNT_W    = 3,
    parameter int  THRESH   = 5,
    localparam int IDW      = $clog2(NBTN)
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic [NBTN-1:0] btn_in,
    output logic [NBTN-1:0] btn_state,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [IDW-1:0]  evt_id,
    output logic            evt_press
`ifdef BTN_SCAN_OVF_EN
    ,
    output logic [NBTN-1:0] evt_ovf,
    input  logic            ovf_clr
`endif
);
    localparam int PS_W = $clog2(PRESCALE);

    logic [NBTN-1:0]  sync1_r;
    logic [NBTN-1:0]  sync2_r;
    logic [PS_W-1:0]  presc_r;
    logic [IDW-1:0]   ptr_r;
    logic [CNT_W-1:0] cnt_r [NBTN];
    logic [NBTN-1:0]  pend_r;
    logic [NBTN-1:0]  ptype_r;
    logic [IDW-1:0]   last_grant_r;

    logic             tick_s;
    logic             svc_diff_s;
    logic [NBTN-1:0]  set_mask_s;
    logic [NBTN-1:0]  clr_mask_s;
    logic [NBTN-1:0]  pend_nxt_s;
    logic             grant_found_s;
    logic [IDW-1:0]   grant_id_s;
    logic [IDW-1:0]   cand_s;
    logic             load_s;

    assign tick_s = (presc_r == PS_W'(PRESCALE - 1));
    assign load_s = !evt_valid || evt_ready;

    // Input synchroniser, scan prescaler and round-robin scan pointer
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            sync1_r <= '0;
            sync2_r <= '0;
            presc_r <= '0;
            ptr_r   <= '0;
        end else begin
            sync1_r <= btn_in;
            sync2_r <= sync1_r;
            presc_r <= tick_s ? '0 : presc_r + PS_W'(1);
            if (tick_s) begin
                ptr_r <= (ptr_r == IDW'(NBTN - 1)) ? '0 : ptr_r + IDW'(1);
            end
        end
    end

    // Decide whether the serviced button accepts a change on this tick
    always_comb begin
        svc_diff_s = sync2_r[ptr_r] ^ btn_state[ptr_r];
        if (tick_s && svc_diff_s && (cnt_r[ptr_r] == CNT_W'(THRESH - 1))) begin
            set_mask_s = NBTN'(1'b1) << ptr_r;
        end else begin
            set_mask_s = '0;
        end
    end

    // Per-button stable-sample counter and debounced level, updated only for the serviced button
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            for (int i = 0; i < NBTN; i++) begin
                cnt_r[i] <= '0;
            end
            btn_state <= '0;
            ptype_r   <= '0;
        end else if (tick_s) begin
            if (!svc_diff_s) begin
                cnt_r[ptr_r] <= '0;
            end else if (set_mask_s[ptr_r]) begin
                cnt_r[ptr_r]     <= '0;
                btn_state[ptr_r] <= ~btn_state[ptr_r];
                ptype_r[ptr_r]   <= ~btn_state[ptr_r];
            end else begin
                cnt_r[ptr_r] <= cnt_r[ptr_r] + CNT_W'(1);
            end
        end
    end

    // Round-robin search for the next pending button, starting just after the last grant
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = last_grant_r;
        cand_s        = '0;
        for (int k = 1; k <= NBTN; k++) begin
            cand_s = IDW'((int'(last_grant_r) + k) % NBTN);
            if (!grant_found_s && pend_r[cand_s]) begin
                grant_found_s = 1'b1;
                grant_id_s    = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Pending update: a new edge landing on the slot being taken stays pending
    always_comb begin
        if (load_s && grant_found_s) begin
            clr_mask_s = NBTN'(1'b1) << grant_id_s;
        end else begin
            clr_mask_s = '0;
        end
        pend_nxt_s = (pend_r & ~clr_mask_s) | set_mask_s;
    end

    // Pending bits and the registered event output stage
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            pend_r       <= '0;
            evt_valid    <= 1'b0;
            evt_id       <= '0;
            evt_press    <= 1'b0;
            last_grant_r <= IDW'(NBTN - 1);
        end else begin
            pend_r <= pend_nxt_s;
            if (load_s) begin
                if (grant_found_s) begin
                    evt_valid    <= 1'b1;
                    evt_id       <= grant_id_s;
                    evt_press    <= ptype_r[grant_id_s];
                    last_grant_r <= grant_id_s;
                end else begin
                    evt_valid <= 1'b0;
                end
            end
        end
    end

`ifdef BTN_SCAN_OVF_EN
    // Sticky overwrite flags; a fresh overwrite beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            evt_ovf <= '0;
        end else begin
            evt_ovf <= (ovf_clr ? '0 : evt_ovf) | (set_mask_s & pend_r & ~clr_mask_s);
        end
    end
`endif

endmodule

// File: tb/tb_btn_scan_ctrl.sv
// Self-checking bench for btn_scan_ctrl: vector table, directed arbitration/overwrite/reset
// sequences, and randomized inputs checked against a behavioural debounce model.
module tb_btn_scan_ctrl;
    localparam int NBTN     = 4;
    localparam int PRESCALE = 4;
    localparam int CNT_W    = 3;
    localparam int THRESH   = 3;

    logic       clk       = 1'b0;
    logic       n_reset   = 1'b0;
    logic [3:0] btn_in    = 4'b0000;
    logic       evt_ready = 1'b0;
    logic [3:0] btn_state;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_press;
`ifdef BTN_SCAN_OVF_EN
    logic [3:0] evt_ovf;
    logic       ovf_clr = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0] id;
        logic       press;
    } ev_t;
    ev_t got[$];

    typedef struct {
        logic [3:0] btn;
        logic       rdy;
        int         ncyc;
        logic [3:0] st;
        logic       vld;
        logic [1:0] id;
        logic       press;
        int         xfers;
    } vec_t;
    vec_t tbl [11];

    // behavioural model state for the random phase
    int         m_n;
    logic [3:0] m_s1, m_s2, m_state;
    int         m_streak [4];
    int         m_pipe_id, m_vis_id;
    logic       m_pipe_press, m_vis_press;

    always #5 clk = ~clk;

    btn_scan_ctrl #(
        .NBTN(NBTN), .PRESCALE(PRESCALE), .CNT_W(CNT_W), .THRESH(THRESH)
    ) dut (
        .clk(clk), .n_reset(n_reset), .btn_in(btn_in), .btn_state(btn_state),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id), .evt_press(evt_press)
`ifdef BTN_SCAN_OVF_EN
        , .evt_ovf(evt_ovf), .ovf_clr(ovf_clr)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_ev(input int k, input int id, input logic press);
        if (k < got.size()) begin
            check($sformatf("ev%0d_id", k), 32'(got[k].id), 32'(id));
            check($sformatf("ev%0d_press", k), 32'(got[k].press), 32'(press));
        end else begin
            checks++;
            errors++;
            $display("FAIL ev%0d missing: got %0d events, required at least %0d", k, got.size(), k + 1);
        end
    endtask

    // advance n cycles from a negedge, logging transfers and checking stall stability
    task automatic run(input int n);
        logic       hold;
        logic [3:0] snap;
        for (int k = 0; k < n; k++) begin
            if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
                got.push_back('{id: evt_id, press: evt_press});
            end
            hold = (evt_valid === 1'b1) && (evt_ready === 1'b0);
            snap = {evt_valid, evt_id, evt_press};
            @(negedge clk);
            if (hold) check("hold", {evt_valid, evt_id, evt_press}, snap);
        end
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic model_reset();
        m_n = 0; m_s1 = '0; m_s2 = '0; m_state = '0;
        for (int i = 0; i < 4; i++) m_streak[i] = 0;
        m_pipe_id = -1; m_vis_id = -1; m_pipe_press = 1'b0; m_vis_press = 1'b0;
    endtask

    // one clock edge of the model: button i is looked at every NBTN*PRESCALE cycles and
    // flips after THRESH consecutive disagreeing looks; its event is visible two edges later
    task automatic model_edge(input logic [3:0] b);
        int   i;
        int   tog;
        logic tog_press;
        tog = -1;
        tog_press = 1'b0;
        if (m_n % PRESCALE == PRESCALE - 1) begin
            i = (m_n / PRESCALE) % NBTN;
            if (m_s2[i] != m_state[i]) begin
                m_streak[i] = m_streak[i] + 1;
                if (m_streak[i] == THRESH) begin
                    m_state[i]  = ~m_state[i];
                    m_streak[i] = 0;
                    tog         = i;
                    tog_press   = m_state[i];
                end
            end else begin
                m_streak[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = b;
        m_n++;
        m_vis_id     = m_pipe_id;
        m_vis_press  = m_pipe_press;
        m_pipe_id    = tog;
        m_pipe_press = tog_press;
    endtask

    initial begin
        //            btn      rdy   n    state   vld   id     press xfers
        tbl[0]  = '{4'b0100, 1'b0,  43, 4'b0000, 1'b0, 2'd0, 1'b0, 0};
        tbl[1]  = '{4'b0100, 1'b0,   1, 4'b0100, 1'b0, 2'd0, 1'b0, 0};
        tbl[2]  = '{4'b0100, 1'b0,   1, 4'b0100, 1'b1, 2'd2, 1'b1, 0};
        tbl[3]  = '{4'b0100, 1'b0, 200, 4'b0100, 1'b1, 2'd2, 1'b1, 0};
        tbl[4]  = '{4'b0100, 1'b1,   1, 4'b0100, 1'b0, 2'd0, 1'b0, 1};
        tbl[5]  = '{4'b0110, 1'b1,  40, 4'b0100, 1'b0, 2'd0, 1'b0, 0};
        tbl[6]  = '{4'b0100, 1'b1,  40, 4'b0100, 1'b0, 2'd0, 1'b0, 0};
        tbl[7]  = '{4'b0110, 1'b1,  49, 4'b0100, 1'b0, 2'd0, 1'b0, 0};
        tbl[8]  = '{4'b0110, 1'b1,   1, 4'b0110, 1'b0, 2'd0, 1'b0, 0};
        tbl[9]  = '{4'b0110, 1'b1,   1, 4'b0110, 1'b1, 2'd1, 1'b1, 0};
        tbl[10] = '{4'b0110, 1'b1,   1, 4'b0110, 1'b0, 2'd0, 1'b0, 1};

        do_reset();
        check("rst_state", 32'(btn_state), 32'h0);
        check("rst_valid", 32'(evt_valid), 32'h0);
        check("rst_id", 32'(evt_id), 32'h0);
        check("rst_press", 32'(evt_press), 32'h0);
`ifdef BTN_SCAN_OVF_EN
        check("rst_ovf", 32'(evt_ovf), 32'h0);
`endif

        // vector table: clean press on button 2, long stall, short glitch on button 1
        for (int v = 0; v < 11; v++) begin
            int n0;
            btn_in    = tbl[v].btn;
            evt_ready = tbl[v].rdy;
            n0        = got.size();
            run(tbl[v].ncyc);
            check($sformatf("v%0d_state", v), 32'(btn_state), 32'(tbl[v].st));
            check($sformatf("v%0d_valid", v), 32'(evt_valid), 32'(tbl[v].vld));
            if (tbl[v].vld) begin
                check($sformatf("v%0d_id", v), 32'(evt_id), 32'(tbl[v].id));
                check($sformatf("v%0d_press", v), 32'(evt_press), 32'(tbl[v].press));
            end
            check($sformatf("v%0d_xfers", v), 32'(got.size() - n0), 32'(tbl[v].xfers));
        end

        // round robin: occupant id1, then 0 and 3 pending -> 3 is served before 0
        evt_ready = 1'b0;
        got.delete();
        btn_in ^= 4'b0010;
        run(64);
        check("rrA_occ_valid", 32'(evt_valid), 32'h1);
        check("rrA_occ_id", 32'(evt_id), 32'h1);
        btn_in ^= 4'b1001;
        run(64);
        evt_ready = 1'b1;
        run(8);
        check("rrA_count", 32'(got.size()), 32'd3);
        check_ev(0, 1, 1'b0);
        check_ev(1, 3, 1'b1);
        check_ev(2, 0, 1'b1);
        check("rrA_state", 32'(btn_state), 32'b1101);

        // repeat after last_grant=0: occupant id2, releases of 0 and 3 -> 3 then 0
        evt_ready = 1'b0;
        got.delete();
        btn_in ^= 4'b0100;
        run(64);
        btn_in ^= 4'b1001;
        run(64);
        evt_ready = 1'b1;
        run(8);
        check("rrB_count", 32'(got.size()), 32'd3);
        check_ev(0, 2, 1'b0);
        check_ev(1, 3, 1'b0);
        check_ev(2, 0, 1'b0);
        check("rrB_valid", 32'(evt_valid), 32'h0);

        // overwrite: button 1 press then release behind a stalled occupant
        evt_ready = 1'b0;
        got.delete();
        btn_in ^= 4'b0100;
        run(64);
        btn_in ^= 4'b0010;
        run(64);
        btn_in ^= 4'b0010;
        run(64);
`ifdef BTN_SCAN_OVF_EN
        check("ovf_set", 32'(evt_ovf), 32'b0010);
        ovf_clr = 1'b1;
        run(1);
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(evt_ovf), 32'h0);
`endif
        evt_ready = 1'b1;
        run(8);
        check("ovw_count", 32'(got.size()), 32'd2);
        check_ev(0, 2, 1'b1);
        check_ev(1, 1, 1'b0);
        check("ovw_state", 32'(btn_state), 32'b0100);

        // reset while an event is presented and counters are mid-count
        evt_ready = 1'b0;
        btn_in ^= 4'b1000;
        run(64);
        btn_in = 4'b0001;
        run(20);
        check("pre_rst_valid", 32'(evt_valid), 32'h1);
        n_reset = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        check("mid_rst_state", 32'(btn_state), 32'h0);
        check("mid_rst_valid", 32'(evt_valid), 32'h0);
        check("mid_rst_id", 32'(evt_id), 32'h0);
        check("mid_rst_press", 32'(evt_press), 32'h0);
        run(35);
        check("post_rst_wait", 32'(btn_state), 32'h0);
        run(1);
        check("post_rst_accept", 32'(btn_state), 32'b0001);
        run(1);
        check("post_rst_valid", 32'(evt_valid), 32'h1);
        check("post_rst_id", 32'(evt_id), 32'h0);
        check("post_rst_press", 32'(evt_press), 32'h1);

        // randomized bouncing inputs against the behavioural model, consumer always ready
        evt_ready = 1'b1;
        btn_in    = 4'b0000;
        n_reset   = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        model_reset();
        for (int k = 0; k < 3000; k++) begin
            int b;
            check("rnd_state", 32'(btn_state), 32'(m_state));
            check("rnd_valid", 32'(evt_valid), 32'(m_vis_id >= 0));
            if (m_vis_id >= 0) begin
                check("rnd_id", 32'(evt_id), 32'(m_vis_id));
                check("rnd_press", 32'(evt_press), 32'(m_vis_press));
            end
            if ($urandom_range(0, 29) == 0) begin
                b = $urandom_range(0, 3);
                btn_in[b] = ~btn_in[b];
            end
            model_edge(btn_in);
            @(negedge clk);
        end
`ifdef BTN_SCAN_OVF_EN
        check("rnd_ovf", 32'(evt_ovf), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/btn_scan_ctrl.md
Name: btn_scan_ctrl

Overview:
Shared-resource debounce scheduler for NBTN mechanical buttons (Cu board, 100 MHz clk). One prescaler and a round-robin scan pointer time-share the debounce logic across all buttons. Each button keeps only a small stable-sample counter. Press and release edges become queued events, presented to downstream logic through a valid/ready port with round-robin arbitration.

Parameters:
NBTN, 4, number of button inputs (>=2)
PRESCALE, 50000, clk cycles between scan ticks (>=2)
CNT_W, 3, width of per-button stable-sample counter
THRESH, 5, consecutive differing samples required to accept a change (2..2^CNT_W)
IDW, $clog2(NBTN), width of event id (derived, localparam)

Ports:
clk  input  1  system clock
n_reset  input  1  reset (synchronous, active-low)
btn_in  input  NBTN  raw asynchronous button levels, active-high
btn_state  output  NBTN  debounced level per button
evt_valid  output  1  event available
evt_ready  input  1  consumer accepts event
evt_id  output  IDW  index of button producing the event
evt_press  output  1  1 = press (0->1), 0 = release (1->0)

Behaviour:
- Reset: n_reset is synchronous, active-low; clock is clk. While reset is low at a clk edge, all of the following clear to 0: synchronisers, prescaler, scan pointer, counters, btn_state, pending bits, evt_valid, evt_id, evt_press. last_grant resets to NBTN-1. Reset mid-event drops every queued and presented event; evt_valid is 0 after that edge.
- Sync: 2-FF synchroniser per btn_in bit. Debounce logic uses only the second stage (s2).
- Prescaler: counts 0..PRESCALE-1 and wraps to 0. tick = 1 for exactly the one cycle where count == PRESCALE-1.
- Scan pointer ptr (IDW bits): advances on tick and wraps NBTN-1 -> 0. Each button is serviced once every NBTN*PRESCALE cycles.
- Service of button i=ptr, on a tick cycle:
  - If s2[i] == btn_state[i]: cnt[i] <= 0.
  - Else if cnt[i] == THRESH-1: btn_state[i] toggles, cnt[i] <= 0, pend[i] <= 1, ptype[i] <= new btn_state[i].
  - Else: cnt[i] <= cnt[i] + 1.
  - cnt never exceeds THRESH-1. Non-serviced buttons hold cnt and state.
- A change is accepted after THRESH consecutive services that all differ from btn_state. Any agreeing sample restarts the count.
- Output register (evt_valid/evt_id/evt_press): loads when evt_valid==0 or (evt_valid && evt_ready).
  - Source: first set pend[] bit searching from last_grant+1 upward, with wrap.
  - On load: pend[j] clears and last_grant <= j. If no pend bit is set, evt_valid <= 0.
- Latency: service on tick cycle T sets pend at edge T. With the output free, evt_valid=1 in cycle T+2.
- Handshake: while evt_valid && !evt_ready, evt_id and evt_press hold stable. Transfer occurs on a cycle with valid && ready. Back-to-back transfers are allowed, one per cycle.
- Simultaneous set/clear on the same pend[j] in one cycle: set wins and the new event stays pending.
- New event for button j while pend[j]=1 (not yet taken): ptype[j] is overwritten and only the latest edge survives (see optional feature).
- btn_state updates in the same edge as pend, independent of evt_ready.

Optional Feature:
Macro BTN_SCAN_OVF_EN.
- Defined: adds ports evt_ovf output NBTN and ovf_clr input 1.
  - evt_ovf[j] is sticky, set when a new event for j occurs while pend[j]=1.
  - A single-cycle ovf_clr=1 clears all bits. If set and clear coincide, set wins.
  - Reset value 0.
- Undefined: ports absent; overwrite is silent. Debounce and event behaviour are otherwise identical.

Test Plan:
- Bench params NBTN=4, PRESCALE=4, THRESH=3. btn_in[2] 0->1 held -> btn_state[2]=1 after the 3rd service of button 2; one event id=2 press=1 with evt_ready=1; no other events.
- btn_in[1] high for exactly 2 services of button 1, then low -> btn_state[1] stays 0; no event; cnt[1] back to 0.
- btn_in[0] and btn_in[3] rise in the same cycle, evt_ready=1 -> two events: id=0 then id=3, each press=1; round-robin order holds on a repeat after last_grant=0.
- evt_ready=0 for 200 cycles with one event pending -> evt_valid stays 1, id/press constant; ready=1 for one cycle -> exactly one transfer, then evt_valid=0.
- Press then release on button 1 with ready=0 -> only id=1 press=0 is delivered. With BTN_SCAN_OVF_EN: evt_ovf=4'b0010 until ovf_clr pulse, then 0.
- n_reset=0 for one cycle while evt_valid=1 and counters mid-count -> next cycle all outputs 0; first post-reset event needs a full THRESH services.
